// File: rtl/mem_bus_ctrl_if.sv
// CPU-side request/response and device-side bus signals of the data-memory controller.
interface mem_bus_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        exc;
  logic [4:0]  exccode;
  logic [31:0] rdata;
  logic [2:0]  dev_sel;
  logic        dev_req;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_we;
  logic        dev_ack;
  logic [31:0] dev_rdata;

  modport master (
    output req, we, size, addr, wdata, dev_ack, dev_rdata,
    input  stall, done, exc, exccode, rdata, dev_sel, dev_req,
           bus_addr, bus_wdata, bus_be, bus_we
  );

  modport slave (
    input  req, we, size, addr, wdata, dev_ack, dev_rdata,
    output stall, done, exc, exccode, rdata, dev_sel, dev_req,
           bus_addr, bus_wdata, bus_be, bus_we
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Data-memory bus controller: decodes M-stage loads/stores, drives the device bus
// and reports completion, address exceptions and device timeouts.
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic           clk,
  input logic           reset,
  mem_bus_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for req; decodes and latches the access on req
  // BUSY  | device access in flight, counting cycles toward TIMEOUT
  // RESP  | one-cycle done pulse carrying status
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic [2:0]  sel;
  logic [3:0]  be;
  logic [31:0] lane_wdata;

  always_comb begin
    is_byte    = bus.size == 2'b00;
    is_half    = bus.size == 2'b01;
    is_word    = bus.size[1];
    misaligned = (is_half && bus.addr[0]) || (is_word && bus.addr[1:0] != 2'b00);
    sel = 3'b000;
    if (bus.addr <= 32'h0000_1FFF)
      sel = 3'b001;
    else if (is_word && bus.addr >= 32'h0000_7F00 &&
             bus.addr <= (bus.we ? 32'h0000_7F07 : 32'h0000_7F0B))
      sel = 3'b010;
    else if (is_word && bus.addr >= 32'h0000_7F10 && bus.addr <= 32'h0000_7F43)
      sel = 3'b100;
    if (misaligned)
      sel = 3'b000;
    be         = 4'b1111;
    lane_wdata = bus.wdata;
    if (is_byte) begin
      be         = 4'b0001 << bus.addr[1:0];
      lane_wdata = {4{bus.wdata[7:0]}};
    end else if (is_half) begin
      be         = 4'b0011 << bus.addr[1:0];
      lane_wdata = {2{bus.wdata[15:0]}};
    end
  end

  assign bus.stall = bus.req && (state != RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.done      <= 1'b0;
      bus.exc       <= 1'b0;
      bus.exccode   <= '0;
      bus.rdata     <= '0;
      bus.dev_req   <= 1'b0;
      bus.dev_sel   <= '0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_be    <= '0;
      bus.bus_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            if (sel != 3'b000) begin
              bus.dev_req   <= 1'b1;
              bus.dev_sel   <= sel;
              bus.bus_addr  <= bus.addr;
              bus.bus_wdata <= lane_wdata;
              bus.bus_be    <= be;
              bus.bus_we    <= bus.we;
              cnt           <= '0;
              state         <= BUSY;
            end else begin
              // address faults complete without ever touching the bus
              bus.done    <= 1'b1;
              bus.exc     <= 1'b1;
              bus.exccode <= bus.we ? 5'd5 : 5'd4;
              state       <= RESP;
            end
          end
        end
        BUSY: begin
          if (bus.dev_ack || cnt == CNT_LAST) begin
            if (bus.dev_ack) begin
              bus.rdata   <= bus.dev_rdata;
              bus.exc     <= 1'b0;
              bus.exccode <= '0;
            end else begin
              bus.exc     <= 1'b1;
              bus.exccode <= 5'd7;
            end
            bus.done    <= 1'b1;
            bus.dev_req <= 1'b0;
            bus.dev_sel <= '0;
            bus.bus_be  <= '0;
            bus.bus_we  <= 1'b0;
            cnt         <= '0;
            state       <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          bus.done    <= 1'b0;
          bus.exc     <= 1'b0;
          bus.exccode <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized bench for mem_bus_ctrl: a byte-range address-map model predicts
// decode, lane steering, status codes and done timing for each transaction.
module tb_mem_bus_ctrl;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_ctrl_if bus();

  mem_bus_ctrl #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_rdata;

  typedef struct {
    bit          legal;
    logic [2:0]  sel;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [4:0]  code;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // An access covers bytes [a, a+nb-1]; it is legal when aligned and that whole
  // byte range lies inside one window that admits its width and direction.
  function automatic exp_t model(input bit we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t   e;
    int     nb;
    longint a;
    longint last;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a = longint'(addr);
    last = a + nb - 1;
    e.sel = 3'b000;
    e.be = 4'b0000;
    e.bwd = 32'h0;
    if (a % nb == 0) begin
      if (last <= 'h1FFF) e.sel = 3'b001;
      else if (nb == 4 && a >= 'h7F00 && last <= (we ? 'h7F07 : 'h7F0B)) e.sel = 3'b010;
      else if (nb == 4 && a >= 'h7F10 && last <= 'h7F43) e.sel = 3'b100;
    end
    e.legal = (e.sel != 3'b000);
    e.code = e.legal ? 5'd0 : (we ? 5'd5 : 5'd4);
    if (e.legal)
      for (int i = 0; i < nb; i++) e.be[int'(a % 4) + i] = 1'b1;
    for (int j = 0; j < 4; j++) e.bwd[8*j +: 8] = wd[8*(j % nb) +: 8];
    return e;
  endfunction

  task automatic scramble();
    bus.we    = 1'($urandom);
    bus.size  = 2'($urandom);
    bus.addr  = $urandom;
    bus.wdata = $urandom;
  endtask

  // ack_at: BUSY cycle index (0-based) carrying dev_ack; >= TO means never.
  task automatic run_txn(input bit we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                         input bit wild, input bit hold_resp);
    exp_t e;
    logic [4:0] code;
    e = model(we, size, addr, wd);
    @(negedge clk);
    bus.req = 1'b1; bus.we = we; bus.size = size; bus.addr = addr; bus.wdata = wd;
    bus.dev_ack = 1'b0;
    #1;
    chk("idle_stall", bus.stall, 1);
    chk("idle_done", bus.done, 0);
    chk("idle_dev_req", bus.dev_req, 0);
    code = e.code;
    if (e.legal) begin
      code = (ack_at < TO) ? 5'd0 : 5'd7;
      for (int b = 0; b < TO; b++) begin
        @(negedge clk);
        if (wild) begin
          scramble();
          bus.req = ($urandom_range(0, 3) != 0);
        end
        bus.dev_ack = (b == ack_at);
        bus.dev_rdata = (b == ack_at) ? rd : $urandom;
        #1;
        chk("busy_dev_req", bus.dev_req, 1);
        chk("busy_dev_sel", bus.dev_sel, e.sel);
        chk("busy_addr", bus.bus_addr, addr);
        chk("busy_be", bus.bus_be, e.be);
        chk("busy_wdata", bus.bus_wdata, e.bwd);
        chk("busy_we", bus.bus_we, we);
        chk("busy_done", bus.done, 0);
        chk("busy_stall", bus.stall, bus.req);
        if (b == ack_at) begin
          exp_rdata = rd;
          break;
        end
      end
    end
    @(negedge clk);
    bus.dev_ack = 1'b0;
    if (wild) scramble();
    bus.req = hold_resp;
    #1;
    chk("resp_done", bus.done, 1);
    chk("resp_exc", bus.exc, (code != 5'd0));
    chk("resp_exccode", bus.exccode, code);
    chk("resp_rdata", bus.rdata, exp_rdata);
    chk("resp_dev_req", bus.dev_req, 0);
    chk("resp_dev_sel", bus.dev_sel, 0);
    chk("resp_bus_we", bus.bus_we, 0);
    chk("resp_stall", bus.stall, 0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.req = 1'b0;
    scramble();
    #1;
    chk("gap_done", bus.done, 0);
    chk("gap_exc", bus.exc, 0);
    chk("gap_exccode", bus.exccode, 0);
    chk("gap_stall", bus.stall, 0);
    chk("gap_dev_req", bus.dev_req, 0);
    chk("gap_dev_sel", bus.dev_sel, 0);
    chk("gap_bus_we", bus.bus_we, 0);
  endtask

  task automatic reset_mid_busy();
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.addr = 32'h7F40; bus.wdata = 32'h0;
    bus.dev_ack = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      if (b == 2) reset = 1'b1;
      #1;
      chk("rst_busy_dev_req", bus.dev_req, 1);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.req = 1'b0;
    #1;
    exp_rdata = 32'h0;
    chk("rst_dev_req", bus.dev_req, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dev_sel", bus.dev_sel, 0);
    chk("rst_bus_be", bus.bus_be, 0);
    chk("rst_bus_we", bus.bus_we, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_stall", bus.stall, 0);
    idle_cycle();
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.addr = 32'h0; bus.wdata = 32'h0;
    bus.dev_ack = 1'b0; bus.dev_rdata = 32'h0;
    exp_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_stall", bus.stall, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_exc", bus.exc, 0);
    chk("reset_exccode", bus.exccode, 0);
    chk("reset_rdata", bus.rdata, 0);
    chk("reset_dev_req", bus.dev_req, 0);
    chk("reset_dev_sel", bus.dev_sel, 0);
    chk("reset_bus_we", bus.bus_we, 0);
    chk("reset_bus_be", bus.bus_be, 0);
    reset = 1'b0;

    run_txn(1'b0, 2'd2, 32'h0000_1FFC, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    idle_cycle();
    run_txn(1'b1, 2'd2, 32'h0000_7F08, 32'h1234_5678, 0, 32'h0, 1'b0, 1'b0);
    run_txn(1'b0, 2'd2, 32'h0000_7F08, 32'h0, 1, 32'h0000_00C3, 1'b0, 1'b0);
    run_txn(1'b0, 2'd1, 32'h0000_0003, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    run_txn(1'b1, 2'd0, 32'h0000_7F10, 32'h55, 0, 32'h0, 1'b0, 1'b0);
    run_txn(1'b1, 2'd0, 32'h0000_0002, 32'h0000_00AB, 0, 32'h0BAD_F00D, 1'b0, 1'b0);
    run_txn(1'b1, 2'd1, 32'h0000_0006, 32'hFFFF_1234, 2, 32'h1, 1'b0, 1'b0);
    run_txn(1'b0, 2'd3, 32'h0000_7F40, 32'h0, TO + 5, 32'h0, 1'b0, 1'b0);
    idle_cycle();
    reset_mid_busy();
    run_txn(1'b0, 2'd2, 32'h0000_0100, 32'h0, 0, 32'h0102_0304, 1'b0, 1'b0);
    run_txn(1'b0, 2'd2, 32'h0000_0200, 32'h0, 2, 32'hA5A5_0001, 1'b0, 1'b1);
    run_txn(1'b0, 2'd2, 32'h0000_0204, 32'h0, 2, 32'hA5A5_0002, 1'b0, 1'b0);
    run_txn(1'b1, 2'd2, 32'h0000_7F04, 32'h7777_8888, TO - 1, 32'h9, 1'b1, 1'b0);

    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 2))
        0:       a = $urandom_range(0, 32'h2003);
        1:       a = 32'h7EF0 + $urandom_range(0, 32'h60);
        default: a = $urandom;
      endcase
      run_txn(1'($urandom), 2'($urandom), a, $urandom, $urandom_range(0, TO + 3), $urandom,
              1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
